// File: rtl/round_controller_if.sv
// Signal bundle between the VGA pixel pipeline / trigger input and the
// round controller. "master" is the side that produces pixel position,
// layer coverage and the trigger; "slave" is the round controller itself.
interface round_controller_if;
  logic       fire;         // raw trigger button, asynchronous to the frame
  logic [9:0] hcount;       // current VGA column
  logic [9:0] vcount;       // current VGA row
  logic       duck_draw;    // duck layer opaque at current pixel
  logic       shot_drawer;  // bullet layer opaque at current pixel
  logic       fire_pulse;   // one-cycle launch strobe to the shot builder
  logic [2:0] shots_left;   // remaining shots in magazine
  logic [7:0] score;        // hits this round
  logic [1:0] state;        // 0 IDLE, 1 PLAY, 2 RELOAD, 3 DONE
  logic       round_over;   // high while in DONE

  modport master (
    output fire, hcount, vcount, duck_draw, shot_drawer,
    input  fire_pulse, shots_left, score, state, round_over
  );

  modport slave (
    input  fire, hcount, vcount, duck_draw, shot_drawer,
    output fire_pulse, shots_left, score, state, round_over
  );
endinterface

// File: rtl/round_controller.sv
// Round controller for a duck-shooting game on a VGA pixel clock.
// Debounces the trigger at frame rate, counts at most one hit per frame,
// tracks the magazine and sequences IDLE / PLAY / (RELOAD) / DONE.
// Optional feature macro: ROUND_CTRL_RELOAD_EN -- when defined, running out
// of shots enters a timed RELOAD state; when undefined it ends the round.
module round_controller #(
  parameter int MAX_SHOTS     = 3,   // shots per magazine (1..7)
  parameter int RELOAD_FRAMES = 30,  // frames spent reloading (1..255)
  parameter int WIN_SCORE     = 10   // hits that end a round (1..255)
) (
  input  logic              vga_clk,
  input  logic              reset,
  round_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef ROUND_CTRL_RELOAD_EN
  localparam logic [1:0] S_RELOAD    = 2'd2;
  localparam logic [7:0] RELOAD_LAST = 8'(RELOAD_FRAMES - 1);
`endif
  // Encoding 2 is reserved for RELOAD and never produced without the feature.

  localparam logic [2:0] FULL_MAG = 3'(MAX_SHOTS);
  localparam logic [7:0] WIN_LVL  = 8'(WIN_SCORE);

  // Empty marker scope that only appears when a parameter is out of range.
  if (MAX_SHOTS < 1 || MAX_SHOTS > 7 || RELOAD_FRAMES < 1 || RELOAD_FRAMES > 255 ||
      WIN_SCORE < 1 || WIN_SCORE > 255) begin : g_param_out_of_range
  end

  logic       fire_meta_q, fire_sync_q;
  logic       frame_tick_q;
  logic       fire_smp_q, fire_smp_d;
  logic       hit_q, hit_d;
  logic [1:0] state_q, state_d;
  logic [2:0] shots_q, shots_d;
  logic [7:0] score_q, score_d;
  logic       pulse_q, pulse_d;
`ifdef ROUND_CTRL_RELOAD_EN
  logic [7:0] reload_cnt_q, reload_cnt_d;
`endif

  logic       hit_now;
  logic       fire_req;
  logic [7:0] score_bump;

  assign hit_now    = bus.duck_draw & bus.shot_drawer;
  // A request is a rising edge between two consecutive per-frame samples.
  assign fire_req   = frame_tick_q & fire_sync_q & ~fire_smp_q;
  // Score saturates rather than wrapping.
  assign score_bump = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

  // Next-state logic for the round FSM, magazine, score and hit latch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d    = state_q;
    shots_d    = shots_q;
    score_d    = score_q;
    pulse_d    = 1'b0;
    hit_d      = hit_q;
    fire_smp_d = fire_smp_q;
`ifdef ROUND_CTRL_RELOAD_EN
    reload_cnt_d = reload_cnt_q;
`endif
    if (frame_tick_q) fire_smp_d = fire_sync_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Hits outside active play are ignored; a press starts a new round.
        hit_d = 1'b0;
        if (fire_req) begin
          state_d = S_PLAY;
          shots_d = FULL_MAG;
          score_d = 8'd0;
        end
      end

      S_PLAY: begin
        hit_d = hit_q | hit_now;
        if (frame_tick_q) begin
          if (hit_q) begin
            // One hit per frame; pixels of this cycle start the next frame's latch.
            score_d = score_bump;
            hit_d   = hit_now;
            if (score_bump >= WIN_LVL) state_d = S_DONE;
          end else if (shots_q == 3'd0) begin
`ifdef ROUND_CTRL_RELOAD_EN
            state_d      = S_RELOAD;
            reload_cnt_d = 8'd0;
`else
            state_d = S_DONE;
`endif
          end
          // A win on this tick suppresses the launch so no pulse leaves PLAY.
          if (fire_req && shots_q != 3'd0 && state_d == S_PLAY) begin
            pulse_d = 1'b1;
            shots_d = shots_q - 3'd1;
          end
        end
      end

`ifdef ROUND_CTRL_RELOAD_EN
      S_RELOAD: begin
        // Hits still latch while reloading; presses are neither acted on nor queued.
        hit_d = hit_q | hit_now;
        if (frame_tick_q) begin
          if (reload_cnt_q == RELOAD_LAST) begin
            state_d      = S_PLAY;
            shots_d      = FULL_MAG;
            reload_cnt_d = 8'd0;
          end else begin
            reload_cnt_d = reload_cnt_q + 8'd1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        hit_d   = 1'b0;
      end
    endcase
  end

  // Register stage: trigger synchroniser, frame tick and all FSM state.
  always_ff @(posedge vga_clk) begin
    // NOTE: reset is synchronous, so it is simply the first branch inside the clocked block.
    if (reset) begin
      fire_meta_q  <= 1'b0;
      fire_sync_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      fire_smp_q   <= 1'b0;
      hit_q        <= 1'b0;
      state_q      <= S_IDLE;
      shots_q      <= 3'd0;
      score_q      <= 8'd0;
      pulse_q      <= 1'b0;
`ifdef ROUND_CTRL_RELOAD_EN
      reload_cnt_q <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fire_meta_q  <= bus.fire;
      fire_sync_q  <= fire_meta_q;
      frame_tick_q <= (bus.hcount == 10'd0) && (bus.vcount == 10'd0);
      fire_smp_q   <= fire_smp_d;
      hit_q        <= hit_d;
      state_q      <= state_d;
      shots_q      <= shots_d;
      score_q      <= score_d;
      pulse_q      <= pulse_d;
`ifdef ROUND_CTRL_RELOAD_EN
      reload_cnt_q <= reload_cnt_d;
`endif
    end
  end

  assign bus.fire_pulse = pulse_q;
  assign bus.shots_left = shots_q;
  assign bus.score      = score_q;
  assign bus.state      = state_q;
  assign bus.round_over = (state_q == S_DONE);

endmodule

// File: tb/tb_round_controller.sv
// Directed testbench for round_controller on a shrunken 8x4 "frame" so that a
// frame_tick occurs every 32 pixel clocks. Covers both builds of
// ROUND_CTRL_RELOAD_EN via the same macro.
module tb_round_controller;

  localparam int H         = 8;
  localparam int V         = 4;
  localparam int FRAME_PIX = H * V;
  localparam int HIT_START = 8;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  round_controller_if bus ();

  round_controller #(
    .MAX_SHOTS    (3),
    .RELOAD_FRAMES(30),
    .WIN_SCORE    (10)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One bench frame starts at pixel 4 so the origin (pixel 0) falls near its
  // end: fire is stable long before the tick, hits land before it, and the
  // tick's effects are visible when the task returns. Counts fire_pulse cycles.
  task automatic run_frame(input logic f, input int hits, output int pulses);
    pulses = 0;
    for (int i = 0; i < FRAME_PIX; i++) begin
      int p;
      p = (i + 4) % FRAME_PIX;
      @(negedge vga_clk);
      if (bus.fire_pulse === 1'b1) pulses++;
      bus.hcount      = 10'(p % H);
      bus.vcount      = 10'(p / H);
      bus.fire        = f;
      bus.duck_draw   = (i >= HIT_START) && (i < HIT_START + hits);
      bus.shot_drawer = (i >= HIT_START) && (i < HIT_START + hits);
    end
  endtask

  // Reset for one edge with a coincident hit on screen, check every output,
  // then check the cycle after release.
  task automatic do_reset();
    @(negedge vga_clk);
    reset           = 1'b1;
    bus.hcount      = 10'd3;
    bus.vcount      = 10'd1;
    bus.fire        = 1'b0;
    bus.duck_draw   = 1'b1;
    bus.shot_drawer = 1'b1;
    @(negedge vga_clk);
    check("rst_state",      bus.state,      0);
    check("rst_shots",      bus.shots_left, 0);
    check("rst_score",      bus.score,      0);
    check("rst_round_over", bus.round_over, 0);
    check("rst_fire_pulse", bus.fire_pulse, 0);
    reset           = 1'b0;
    bus.duck_draw   = 1'b0;
    bus.shot_drawer = 1'b0;
    @(negedge vga_clk);
    check("post_rst_pulse", bus.fire_pulse, 0);
    check("post_rst_state", bus.state,      0);
  endtask

  initial begin
    int p;
    int total;
    int bad;

    bus.fire        = 1'b0;
    bus.hcount      = 10'd3;
    bus.vcount      = 10'd1;
    bus.duck_draw   = 1'b0;
    bus.shot_drawer = 1'b0;
    do_reset();

    // Fire held for three frames: a single IDLE->PLAY, no launch.
    run_frame(1'b1, 0, p);
    total = p;
    check("idle_to_play_state", bus.state, 1);
    run_frame(1'b1, 0, p);
    total += p;
    run_frame(1'b1, 0, p);
    total += p;
    check("held_fire_state",  bus.state,      1);
    check("held_fire_shots",  bus.shots_left, 3);
    check("held_fire_score",  bus.score,      0);
    check("held_fire_pulses", total,          0);

    // Three separate presses; the third coincides with a hit.
    run_frame(1'b0, 0, p);
    check("release_pulse", p, 0);
    run_frame(1'b1, 0, p);
    check("shot1_pulse", p, 1);
    check("shot1_shots", bus.shots_left, 2);
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 0, p);
    check("shot2_pulse", p, 1);
    check("shot2_shots", bus.shots_left, 1);
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 5, p);
    check("hit_fire_pulse", p, 1);
    check("hit_fire_shots", bus.shots_left, 0);
    check("hit_fire_score", bus.score, 1);
    check("hit_fire_state", bus.state, 1);

    // Empty magazine, no pending hit: exhaustion.
    run_frame(1'b0, 0, p);
    check("exhaust_pulse", p, 0);
`ifdef ROUND_CTRL_RELOAD_EN
    check("exhaust_state",      bus.state,      2);
    check("exhaust_round_over", bus.round_over, 0);
    bad   = 0;
    total = 0;
    for (int k = 1; k < 30; k++) begin
      run_frame(logic'(k % 2), 0, p);
      total += p;
      if (bus.state !== 2'd2) bad++;
    end
    check("reload_state_held", bad, 0);
    run_frame(1'b0, 0, p);
    total += p;
    check("reload_pulses", total, 0);
    check("reload_done_state", bus.state, 1);
    check("reload_done_shots", bus.shots_left, 3);
    check("reload_score_kept", bus.score, 1);

    // Empty the magazine again and reset in the middle of the reload.
    run_frame(1'b1, 0, p);
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 0, p);
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 0, p);
    check("reshoot_shots", bus.shots_left, 0);
    run_frame(1'b0, 0, p);
    check("reexhaust_state", bus.state, 2);
    for (int k = 0; k < 5; k++) run_frame(1'b0, 5, p);
    do_reset();
`else
    check("exhaust_state",      bus.state,      3);
    check("exhaust_round_over", bus.round_over, 1);
    check("exhaust_score",      bus.score,      1);
    check("exhaust_shots",      bus.shots_left, 0);
    run_frame(1'b0, 5, p);
    check("done_hit_ignored", bus.score, 1);
    check("done_pulse",       p,         0);
    run_frame(1'b1, 0, p);
    check("done_restart_state", bus.state,      1);
    check("done_restart_score", bus.score,      0);
    check("done_restart_shots", bus.shots_left, 3);
    check("done_restart_pulse", p,              0);
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 0, p);
    check("midplay_shots", bus.shots_left, 2);
    do_reset();
`endif

    // Fresh round, then ten frames of multi-pixel hits to win.
    run_frame(1'b0, 0, p);
    run_frame(1'b1, 0, p);
    check("win_start_state", bus.state,      1);
    check("win_start_shots", bus.shots_left, 3);
    check("win_start_pulse", p,              0);
    run_frame(1'b0, 0, p);
    check("no_stale_hit_score", bus.score, 0);
    run_frame(1'b0, 5, p);
    check("five_pixels_one_hit", bus.score, 1);
    for (int k = 0; k < 8; k++) run_frame(1'b0, 5, p);
    check("nine_hits_score", bus.score, 9);
    check("nine_hits_state", bus.state, 1);
    run_frame(1'b0, 5, p);
    check("win_state",      bus.state,      3);
    check("win_round_over", bus.round_over, 1);
    check("win_score",      bus.score,      10);
    run_frame(1'b0, 5, p);
    check("win_score_hold", bus.score, 10);
    run_frame(1'b1, 0, p);
    check("replay_state", bus.state,      1);
    check("replay_score", bus.score,      0);
    check("replay_shots", bus.shots_left, 3);
    check("replay_over",  bus.round_over, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter MAX_SHOTS, default 3, shots per magazine (1..7).
REQ-002 SHALL have parameter RELOAD_FRAMES, default 30, frames spent reloading (1..255).
REQ-003 SHALL have parameter WIN_SCORE, default 10, hits that end a round (1..255).
REQ-004 SHALL have port vga_clk  input  1  sole clock, pixel clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fire  input  1  raw trigger button, asynchronous to frame.
REQ-007 SHALL have port hcount  input  10  current VGA column.
REQ-008 SHALL have port vcount  input  10  current VGA row.
REQ-009 SHALL have port duck_draw  input  1  duck layer opaque at current pixel.
REQ-010 SHALL have port shot_drawer  input  1  bullet layer opaque at current pixel.
REQ-011 SHALL have port fire_pulse  output  1  one-cycle launch strobe to the shot builder.
REQ-012 SHALL have port shots_left  output  3  remaining shots in magazine.
REQ-013 SHALL have port score  output  8  hits this round.
REQ-014 SHALL have port state  output  2  FSM state: 0 IDLE, 1 PLAY, 2 RELOAD, 3 DONE.
REQ-015 SHALL have port round_over  output  1  high while state is DONE.

Function
REQ-016 SHALL assert internal frame_tick for exactly one cycle, one cycle after hcount==0 and vcount==0 is sampled.
REQ-017 SHALL sample fire only on frame_tick; a fire request is a 0->1 change between consecutive samples (frame-rate debounce).
REQ-018 SHALL latch hit_pending when duck_draw and shot_drawer are both high in the same cycle, outside DONE/IDLE ignored.
REQ-019 SHALL, on frame_tick in PLAY with hit_pending set, increment score by exactly 1 (max one hit per frame) and clear hit_pending.
REQ-020 SHALL saturate score at 255; no wrap.
REQ-021 IDLE: on fire request -> PLAY, shots_left=MAX_SHOTS, score=0; no fire_pulse for that request.
REQ-022 PLAY: on fire request with shots_left>0 -> fire_pulse high the cycle after frame_tick, shots_left decremented same cycle.
REQ-023 PLAY: when score update reaches WIN_SCORE -> DONE on the same frame_tick; win takes priority over exhaustion.
REQ-024 PLAY: at a frame_tick where shots_left==0 and no hit_pending -> exhaustion transition (see Configuration).
REQ-025 SHALL apply a hit and a fire request arriving on the same frame_tick both, in that frame.
REQ-026 RELOAD: fire requests ignored and not queued; after RELOAD_FRAMES frame_ticks -> PLAY with shots_left=MAX_SHOTS.
REQ-027 DONE: score and shots_left hold; fire request -> PLAY with score=0, shots_left=MAX_SHOTS.
REQ-028 SHALL never assert fire_pulse outside PLAY nor more than once per frame.

Reset
REQ-029 SHALL, while reset is high at a vga_clk edge, set state=IDLE, fire_pulse=0, shots_left=0, score=0, round_over=0, hit_pending=0, reload counter=0, fire sample=0.
REQ-030 SHALL abort any operation mid-reload or mid-play on reset; no fire_pulse in the cycle after reset deasserts.

Configuration
REQ-031 SHALL compile the RELOAD state only when ROUND_CTRL_RELOAD_EN is defined.
REQ-032 With ROUND_CTRL_RELOAD_EN: exhaustion in PLAY -> RELOAD, behaving per REQ-026.
REQ-033 Without ROUND_CTRL_RELOAD_EN: exhaustion in PLAY -> DONE (round lost), state value 2 never produced, RELOAD_FRAMES unused.

Verification
REQ-034 Reset then fire held high 3 frames -> one transition IDLE->PLAY, shots_left=3, score=0, no fire_pulse.
REQ-035 In PLAY, three fire presses on separate frames -> exactly three 1-cycle fire_pulses, shots_left 3->2->1->0.
REQ-036 duck_draw&shot_drawer high on 5 pixels of one frame -> score +1 only; 10 such frames -> state=DONE, round_over=1, score=10.
REQ-037 RELOAD_EN defined, shots exhausted -> state=2 for 30 frame_ticks, presses ignored, then PLAY with shots_left=3; undefined -> DONE.
REQ-038 Hit and fire request on same frame_tick with shots_left=1 -> score+1, fire_pulse, shots_left=0; reset asserted mid-RELOAD -> all outputs per REQ-029 next cycle.
